// File: rtl/clk_gen_ctrl.sv
// -----------------------------------------------------------------------------
// clk_gen_ctrl
//   Programmable clock generator. Produces a registered divided clock clk_out
//   whose period and high time are counted in clk cycles. New settings arrive
//   over a valid/ready handshake and only ever take effect at a period
//   boundary, so clk_out never shows a runt pulse.
//
// Ports
//   clk, rst             : clock, asynchronous active-high reset
//   cfg_valid/cfg_ready  : configuration handshake
//   cfg_period/cfg_high  : requested period P and high time H (clk cycles)
//   cfg_en               : 1 = run with P/H, 0 = stop at the next boundary
//   cfg_err              : one-cycle pulse, last accepted request was invalid
//   clk_out, clk_rise    : generated clock and its rising-cycle marker
//   busy, running        : configuration pending / generator active
//   act_period, act_high : settings currently in effect
// -----------------------------------------------------------------------------
module clk_gen_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  input  logic             cfg_en,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             clk_rise,
  output logic             busy,
  output logic             running,
  output logic [CNT_W-1:0] act_period,
  output logic [CNT_W-1:0] act_high
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sh_period;
  logic [CNT_W-1:0] sh_high;
  logic             sh_en;

  logic             xfer;
  logic             req_ok;
  logic             last;
  logic [CNT_W-1:0] cnt_inc;
  logic             apply_now;
  logic [CNT_W-1:0] nx_period;
  logic [CNT_W-1:0] nx_high;
  logic             nx_en;

  function automatic logic cfg_valid_rule(input logic [CNT_W-1:0] p,
                                          input logic [CNT_W-1:0] h);
    return (p >= CNT_W'(2)) && (h != '0) && (h < p);
  endfunction

  assign xfer    = cfg_valid && cfg_ready;
  assign req_ok  = cfg_valid_rule(cfg_period, cfg_high);
  assign last    = (cnt == act_period - 1'b1);
  assign cnt_inc = cnt + 1'b1;

  // Select which settings get applied this edge and whether an apply happens.
  // In IDLE a valid request with en=0 "applies" a stop, which leaves the
  // generator exactly where it already is -- i.e. a no-op.
  always_comb begin
    nx_period = cfg_period;
    nx_high   = cfg_high;
    nx_en     = cfg_en;
    apply_now = 1'b0;
    case (state)
      IDLE:    apply_now = xfer && req_ok;
      RUN:     apply_now = xfer && req_ok && last;
      PEND: begin
        nx_period = sh_period;
        nx_high   = sh_high;
        nx_en     = sh_en;
        apply_now = last;
      end
      default: apply_now = 1'b0;
    endcase
  end

  // Shadow copy of the request; only consulted while PEND.
  always_ff @(posedge clk) begin
    if (xfer) begin
      sh_period <= cfg_period;
      sh_high   <= cfg_high;
      sh_en     <= cfg_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clk_out    <= 1'b0;
      clk_rise   <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      running    <= 1'b0;
      cfg_ready  <= 1'b1;
      act_period <= '0;
      act_high   <= '0;
    end else begin
      // Rejected requests never change state, so this pulse cannot coincide
      // with a state change.
      cfg_err <= xfer && !req_ok;
      if (apply_now) begin
        cnt       <= '0;
        busy      <= 1'b0;
        cfg_ready <= 1'b1;
        if (nx_en) begin
          state      <= RUN;
          act_period <= nx_period;
          act_high   <= nx_high;
          clk_out    <= 1'b1;
          clk_rise   <= 1'b1;
          running    <= 1'b1;
        end else begin
          state    <= IDLE;
          clk_out  <= 1'b0;
          clk_rise <= 1'b0;
          running  <= 1'b0;
        end
      end else if (state != IDLE) begin
        // Normal counting; every period starts high since act_high >= 1.
        if (last) begin
          cnt      <= '0;
          clk_out  <= 1'b1;
          clk_rise <= 1'b1;
        end else begin
          cnt      <= cnt_inc;
          clk_out  <= (cnt_inc < act_high);
          clk_rise <= 1'b0;
        end
        // A valid request mid-period waits in the shadow for the boundary.
        if (state == RUN && xfer && req_ok) begin
          state     <= PEND;
          busy      <= 1'b1;
          cfg_ready <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// -----------------------------------------------------------------------------
// tb_clk_gen_ctrl
//   Directed bench for clk_gen_ctrl with hand-computed expected waveforms.
// -----------------------------------------------------------------------------
module tb_clk_gen_ctrl;

  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_high;
  logic             cfg_en;
  logic             cfg_err;
  logic             clk_out;
  logic             clk_rise;
  logic             busy;
  logic             running;
  logic [CNT_W-1:0] act_period;
  logic [CNT_W-1:0] act_high;

  int n_chk = 0;
  int n_err = 0;

  clk_gen_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_high   (cfg_high),
    .cfg_en     (cfg_en),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .clk_rise   (clk_rise),
    .busy       (busy),
    .running    (running),
    .act_period (act_period),
    .act_high   (act_high)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int p, input int h, input logic en);
    cfg_valid  = 1'b1;
    cfg_period = CNT_W'(p);
    cfg_high   = CNT_W'(h);
    cfg_en     = en;
    tick();
    cfg_valid  = 1'b0;
  endtask

  // Check n cycles of waveform, assuming the current cycle is cnt=0.
  task automatic run_chk(input string tag, input int p, input int h, input int n);
    for (int k = 0; k < n; k++) begin
      check({tag, ".clk_out"},  clk_out,  ((k % p) < h) ? 32'd1 : 32'd0);
      check({tag, ".clk_rise"}, clk_rise, ((k % p) == 0) ? 32'd1 : 32'd0);
      tick();
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, ".clk_out"},    clk_out,    0);
    check({tag, ".clk_rise"},   clk_rise,   0);
    check({tag, ".cfg_err"},    cfg_err,    0);
    check({tag, ".busy"},       busy,       0);
    check({tag, ".running"},    running,    0);
    check({tag, ".cfg_ready"},  cfg_ready,  1);
    check({tag, ".act_period"}, act_period, 0);
    check({tag, ".act_high"},   act_high,   0);
  endtask

  initial begin
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_high   = '0;
    cfg_en     = 1'b0;

    // Reset
    tick();
    check_reset_vals("rst");
    rst = 1'b0;
    tick();
    check_reset_vals("rel");

    // Start P=4 H=2
    send(4, 2, 1'b1);
    check("start.running",    running,    1);
    check("start.act_period", act_period, 4);
    check("start.act_high",   act_high,   2);
    run_chk("p4h2", 4, 2, 8);

    // Reconfigure to P=5 H=1 at cnt=1
    tick();
    send(5, 1, 1'b1);
    check("pend1.busy",  busy,      1);
    check("pend1.ready", cfg_ready, 0);
    check("pend1.clk",   clk_out,   0);
    tick();
    check("pend2.busy",  busy,      1);
    check("pend2.ready", cfg_ready, 0);
    check("pend2.clk",   clk_out,   0);
    check("pend2.act",   act_period, 4);
    tick();
    check("new.busy",  busy,       0);
    check("new.ready", cfg_ready,  1);
    check("new.act_p", act_period, 5);
    check("new.act_h", act_high,   1);
    run_chk("p5h1", 5, 1, 10);

    // Invalid requests
    send(4, 4, 1'b1);
    check("err1.pulse", cfg_err,    1);
    check("err1.clk",   clk_out,    0);
    check("err1.act_p", act_period, 5);
    check("err1.act_h", act_high,   1);
    check("err1.busy",  busy,       0);
    tick();
    check("err1.clear", cfg_err, 0);
    send(1, 0, 1'b1);
    check("err2.pulse", cfg_err, 1);
    send(0, 0, 1'b1);
    check("err3.pulse", cfg_err,    1);
    check("err3.act_p", act_period, 5);
    tick();
    check("err3.clear", cfg_err, 0);
    run_chk("p5h1b", 5, 1, 5);

    // Minimum P=2 H=1 applied at the last cycle (cnt=4): PEND skipped
    repeat (4) tick();
    send(2, 1, 1'b1);
    check("min.busy",  busy,       0);
    check("min.act_p", act_period, 2);
    check("min.act_h", act_high,   1);
    run_chk("p2h1", 2, 1, 6);

    // Go to P=6 H=3, then stop at cnt=2
    send(6, 3, 1'b1);
    check("p6.busy", busy,    1);
    check("p6.clk",  clk_out, 0);
    tick();
    check("p6.act_p", act_period, 6);
    check("p6.c0",    clk_out,    1);
    tick();
    check("p6.c1", clk_out, 1);
    tick();
    check("p6.c2", clk_out, 1);
    send(6, 3, 1'b0);
    check("stop.c3",      clk_out, 0);
    check("stop.busy",    busy,    1);
    check("stop.running", running, 1);
    tick();
    check("stop.c4", clk_out, 0);
    tick();
    check("stop.c5", clk_out, 0);
    tick();
    check("idle.clk",     clk_out,    0);
    check("idle.rise",    clk_rise,   0);
    check("idle.running", running,    0);
    check("idle.busy",    busy,       0);
    check("idle.ready",   cfg_ready,  1);
    check("idle.act_p",   act_period, 6);
    repeat (3) begin
      tick();
      check("idle.hold", clk_out, 0);
    end

    // Valid en=0 in IDLE is a no-op
    send(4, 2, 1'b0);
    check("noop.running", running,    0);
    check("noop.err",     cfg_err,    0);
    check("noop.act_p",   act_period, 6);

    // Reset mid-period with a pending config
    send(8, 4, 1'b1);
    check("p8.clk", clk_out, 1);
    tick();
    tick();
    send(3, 1, 1'b1);
    check("p8.busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_vals("arst");
    tick();
    rst = 1'b0;
    tick();
    check("post.ready", cfg_ready, 1);
    repeat (10) begin
      check("post.clk",     clk_out, 0);
      check("post.running", running, 0);
      tick();
    end
    send(3, 1, 1'b1);
    check("restart.act_p", act_period, 3);
    run_chk("p3h1", 3, 1, 6);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
